// File: rtl/turn_scheduler.sv
// Round-robin turn scheduler for up to four players.
// Grants the turn to one player, waits for a keypad tile selection, issues a
// single-cycle move request to the move datapath, then on the result keeps the
// player (hit), passes the turn (miss or keypad timeout), or ends the game (win).
module turn_scheduler #(
  parameter int NUM_PLAYERS = 4,
  parameter int TIMEOUT     = 1000,
  parameter int TW          = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] active_mask,
  input  logic [3:0] key,
  input  logic       move_done,
  input  logic       move_hit,
  input  logic       win,
  output logic       move_req,
  output logic [3:0] move_tile,
  output logic [1:0] player,
  output logic       busy,
  output logic       timeout,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_KEY,
    ISSUE,
    WAIT_DONE,
    RELEASE,
    SELECT,
    OVER
  } state_t;

  localparam logic [3:0]    NO_KEY      = 4'hF;
  localparam logic [3:0]    PLAYER_BITS = 4'((1 << NUM_PLAYERS) - 1);
  localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT - 1);

  state_t        state;
  logic [3:0]    mask_q;
  logic          same_player;
  logic [TW-1:0] timer;
  logic [3:0]    eff_mask;

  // Only player slots that physically exist can take part.
  assign eff_mask = active_mask & PLAYER_BITS;

  // Lowest set bit of a mask; callers guarantee the mask is non-zero.
  function automatic logic [1:0] lowest_player(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[2'(i)]) r = 2'(i);
    end
    return r;
  endfunction

  // First set bit searching upwards from cur+1 with wrap-around; falls back to
  // cur when no other player is active. Descending k lets the nearest win.
  function automatic logic [1:0] next_player(input logic [3:0] m,
                                             input logic [1:0] cur);
    logic [1:0] r;
    logic [1:0] idx;
    r = cur;
    for (int k = NUM_PLAYERS - 1; k >= 1; k--) begin
      idx = 2'((int'(cur) + k) % NUM_PLAYERS);
      if (m[idx]) r = idx;
    end
    return r;
  endfunction

  // Turn sequencing FSM; every output is a flop updated alongside the state.
  // NOTE: all state and outputs use non-blocking assignments so every flop
  // samples pre-edge values, and reset is asynchronous so an abort takes effect
  // without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      mask_q      <= 4'd0;
      same_player <= 1'b0;
      timer       <= '0;
      player      <= 2'd0;
      winner      <= 2'd0;
      move_tile   <= 4'd0;
      move_req    <= 1'b0;
      timeout     <= 1'b0;
      busy        <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low here so each branch only raises them
      // for the single cycle that needs them.
      move_req <= 1'b0;
      timeout  <= 1'b0;

      case (state)
        IDLE: begin
          if (start && (eff_mask != 4'd0)) begin
            mask_q <= eff_mask;
            player <= lowest_player(eff_mask);
            timer  <= '0;
            busy   <= 1'b1;
            state  <= WAIT_KEY;
          end
        end

        WAIT_KEY: begin
          if (key != NO_KEY) begin
            // A key on the last timer cycle still wins over the forfeit.
            move_tile <= key;
            move_req  <= 1'b1;
            state     <= ISSUE;
          end else if (timer == TIMER_LAST) begin
            timeout <= 1'b1;
            state   <= SELECT;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ISSUE: begin
          // move_req drops here; a move_done seen now belongs to nothing.
          state <= WAIT_DONE;
        end

        WAIT_DONE: begin
          if (move_done) begin
            if (win) begin
              winner    <= player;
              game_over <= 1'b1;
              state     <= OVER;
            end else begin
              same_player <= move_hit;
              state       <= RELEASE;
            end
          end
        end

        RELEASE: begin
          // Hold off until the keypad reads idle so one press is used once.
          if (key == NO_KEY) begin
            if (same_player) begin
              timer <= '0;
              state <= WAIT_KEY;
            end else begin
              state <= SELECT;
            end
          end
        end

        SELECT: begin
          player <= next_player(mask_q, player);
          timer  <= '0;
          state  <= WAIT_KEY;
        end

        OVER: begin
          if (!start) begin
            game_over <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          game_over <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/turn_scheduler.md
# turn_scheduler

Round-robin turn scheduler that sequences the shared keypad and tile-move datapath between up to four players. Runs one turn at a time:
- grants the turn to a player and waits for a tile selection on the keypad;
- issues a one-cycle move request to the move datapath and waits for its result;
- on a hit, keeps the same player; on a miss, a timeout, or a win, passes the turn on or ends the game.

Sits between the keypad decoder and the board/move datapath, above the per-turn move logic.

## Interface
- NUM_PLAYERS, 4: number of player slots; legal range 2..4. Mask bits at or above NUM_PLAYERS are ignored.
- TIMEOUT, 1000: clock cycles allowed in WAIT_KEY before the turn is forfeited; must be at least 2.
- TW, 16: width of the turn timer; must satisfy 2^TW > TIMEOUT.

Ports (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level input; starts a game when high in IDLE.
- active_mask  in  4  players taking part; latched at game start.
- key  in  4  decoded keypad value; 4'hF means no key pressed.
- move_done  in  1  one-cycle pulse from the datapath: move finished.
- move_hit  in  1  qualified by move_done; 1 means the selected tile matched.
- win  in  1  qualified by move_done; 1 means the current player has won.
- move_req  out  1  one-cycle pulse asking the datapath to execute a move.
- move_tile  out  4  tile index for the move; held stable from ISSUE until the next key is latched.
- player  out  2  index of the player whose turn it is.
- busy  out  1  high in every state except IDLE.
- timeout  out  1  one-cycle pulse when a turn is forfeited.
- game_over  out  1  high in OVER.
- winner  out  2  winning player; valid while game_over is high.

## Operation
States: IDLE, WAIT_KEY, ISSUE, WAIT_DONE, RELEASE, SELECT, OVER.

- **Reset** (rst low, asynchronous): state=IDLE; player=0; winner=0; move_tile=0; latched mask=0; timer=0. All outputs 0. Reset asserted in the middle of a turn or move aborts it immediately; no move_req is issued afterwards.
- **IDLE**: if start=1 and the effective mask is non-zero:
  - latch the mask;
  - player = lowest set mask bit;
  - go to WAIT_KEY.
  If start=1 with an all-zero mask, stay in IDLE.
- **WAIT_KEY**: the timer is cleared on entry and increments every cycle.
  - key≠4'hF: latch key into move_tile and go to ISSUE.
  - Otherwise, when timer==TIMEOUT-1: pulse timeout and go to SELECT.
  - If a key arrives in the same cycle as the timeout, the key wins.
- **ISSUE**: move_req=1 for exactly this cycle, then go to WAIT_DONE. A move_done arriving during ISSUE is ignored.
- **WAIT_DONE**: wait for move_done; no timeout in this state. On move_done:
  - win=1: winner=player, go to OVER. win takes priority over move_hit.
  - else move_hit=1: go to RELEASE with a "same player" flag.
  - else: go to RELEASE with a "next player" flag.
- **RELEASE**: wait until key==4'hF, so a single press can never be consumed twice. Then:
  - same-player flag: go to WAIT_KEY;
  - next-player flag: go to SELECT.
- **SELECT**: player = first set latched-mask bit, searching player+1, player+2, … modulo NUM_PLAYERS.
  - If the current player is the only active one, player is unchanged.
  - Always go to WAIT_KEY.
- **OVER**: game_over=1 and winner is held. Stays here while start=1; when start=0, go to IDLE (player and winner keep their values).
- active_mask changes after the game starts are ignored until the next start in IDLE.

## Timing
- Start to turn: start sampled high at edge t puts WAIT_KEY in effect from t; player is valid from edge t.
- Key to request: key sampled at edge k gives move_req high for the cycle after k. move_tile is valid from edge k.
- Hit turnaround: move_done with hit at edge d gives RELEASE from d; key released at edge r gives WAIT_KEY from r.
- Miss turnaround: RELEASE, then SELECT for one cycle, then WAIT_KEY. The new player value is visible one edge after leaving RELEASE.
- Timeout: a timeout pulse happens exactly TIMEOUT cycles after WAIT_KEY is entered, and timeout is high for one cycle only.
- move_req, timeout: single-cycle pulses. Never asserted in IDLE or OVER, and never both in the same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Start with active_mask=4'b1011 and key held at F: player=0, busy=1. After 1000 cycles, timeout pulses and player becomes 1; after another 1000, player becomes 3; after another 1000, player wraps to 0.
- Player 0 presses key=4'h5: move_req pulses once and move_tile=5. Return move_done=1, hit=1: after the key is released, player stays 0 and a second move_req appears only after a new key press.
- Miss: move_done=1, hit=0 with the key still held for 20 cycles: no SELECT until the key reads F, then player advances to the next active player.
- Win: move_done=1, win=1, hit=0 for player 3: game_over=1, winner=3, no further move_req. With start=0: IDLE, busy=0.
- Boundaries: key arriving on the timeout cycle is issued with no timeout pulse. Mask 4'b0000 with start=1 leaves busy=0. A single-player mask 4'b0100 stays on player 2 after a miss. A move_done during ISSUE is ignored.
- Drive rst low during WAIT_DONE: all outputs return to 0 immediately. After rst is released, no move_req appears until a new start and key press.
